mac_col_nx1: RTL and testbench

MAC_COL_NX1 -- requirements
Module: mac_col_nx1

---
 rtl/mac_col_nx1_pkg.sv | 17 +
 rtl/fxp_round_sat.sv | 54 +++++
 rtl/mac_col_nx1.sv | 143 ++++++++++++++
 tb/tb_mac_col_nx1.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_col_nx1_pkg.sv
// Shared fixed-point definitions for the MAC column: default operand format,
// accumulator guard width and the rounding-mode encodings.
package mac_col_nx1_pkg;

   // Default lane count and fixed-point format (Q8.9 in 18 bits).
   localparam int LANES_DEF    = 4;
   localparam int BIT_NUM_DEF  = 18;
   localparam int FRAC_NUM_DEF = 9;
   localparam int GUARD_DEF    = 4;

   // Rounding modes applied when the accumulator is scaled back to BIT_NUM bits.
   localparam logic [1:0] RND_FLOOR       = 2'd0;  // plain arithmetic shift
   localparam logic [1:0] RND_NEG_INC     = 2'd1;  // floor, +1 LSB when negative
   localparam logic [1:0] RND_HALF_UP     = 2'd2;  // floor(acc + half LSB)
   localparam logic [1:0] RND_HALF_UP_ALT = 2'd3;  // same as RND_HALF_UP

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rescale of one accumulator lane: drops FRAC_NUM fraction bits
// with the selected rounding mode, detects overflow of the BIT_NUM-bit result
// range and either clamps or wraps.
module fxp_round_sat
   import mac_col_nx1_pkg::*;
#(
   parameter int BIT_NUM  = BIT_NUM_DEF,
   parameter int FRAC_NUM = FRAC_NUM_DEF,
   parameter int ACC_W    = 2 * BIT_NUM_DEF + GUARD_DEF
) (
   input  logic [ACC_W-1:0]   acc_i,
   input  logic [1:0]         mode_i,
   input  logic               sat_en_i,
   output logic [BIT_NUM-1:0] val_o,
   output logic               ovf_o
);

   // One extra bit so the half-LSB bias can never overflow the accumulator.
   localparam int XW = ACC_W + 1;

   localparam logic signed [XW-1:0] MAX_V  =
      $signed({{(XW-BIT_NUM+1){1'b0}}, {(BIT_NUM-1){1'b1}}});
   localparam logic signed [XW-1:0] MIN_V  =
      $signed({{(XW-BIT_NUM+1){1'b1}}, {(BIT_NUM-1){1'b0}}});
   localparam logic signed [XW-1:0] HALF_V =
      $signed({{(XW-FRAC_NUM){1'b0}}, 1'b1, {(FRAC_NUM-1){1'b0}}});

   logic signed [XW-1:0] acc_x;
   logic signed [XW-1:0] biased;
   logic signed [XW-1:0] shifted;
   logic signed [XW-1:0] rnd;
   logic                 neg_inc;
   logic                 ovf;

   // Bias, shift, optional negative increment, then range check and clamp/wrap.
   always_comb begin
      acc_x   = $signed({acc_i[ACC_W-1], acc_i});
      biased  = acc_x;
      if ((mode_i == RND_HALF_UP) || (mode_i == RND_HALF_UP_ALT)) begin
         biased = acc_x + HALF_V;
      end
      shifted = biased >>> FRAC_NUM;
      neg_inc = (mode_i == RND_NEG_INC) && acc_i[ACC_W-1];
      rnd     = shifted + $signed({{(XW-1){1'b0}}, neg_inc});
      ovf     = (rnd > MAX_V) || (rnd < MIN_V);
      if (ovf && sat_en_i) begin
         val_o = rnd[XW-1] ? MIN_V[BIT_NUM-1:0] : MAX_V[BIT_NUM-1:0];
      end else begin
         val_o = rnd[BIT_NUM-1:0];
      end
      ovf_o   = ovf;
   end

endmodule

// File: rtl/mac_col_nx1.sv
// LANES-wide column multiply-accumulate: each lane multiplies its element of
// a_vec by the shared scalar b, accumulates over a first..last group and emits
// a rounded/saturated BIT_NUM-bit result per group.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready; a
// result transfers where out_valid && out_ready. The whole pipeline advances
// only when the output register is empty or being drained, so in_ready is that
// advance condition and a stalled consumer freezes every stage in place.
module mac_col_nx1
   import mac_col_nx1_pkg::*;
#(
   parameter int LANES    = LANES_DEF,
   parameter int BIT_NUM  = BIT_NUM_DEF,
   parameter int FRAC_NUM = FRAC_NUM_DEF,
   parameter int GUARD    = GUARD_DEF
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic [LANES*BIT_NUM-1:0] a_vec,
   input  logic [BIT_NUM-1:0]       b,
   input  logic [1:0]               round_mode,
   input  logic                     sat_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*BIT_NUM-1:0] out_vec,
   output logic [LANES-1:0]         out_ovf
);

   localparam int PW = 2 * BIT_NUM;
   localparam int AW = PW + GUARD;

   logic                     adv;
   logic                     res_load;

   // Stage 1: products and group/format controls of the accepted beat.
   logic                     s1_valid_q;
   logic                     s1_first_q;
   logic                     s1_last_q;
   logic                     s1_sat_q;
   logic [1:0]               s1_mode_q;
   logic [PW-1:0]            prod_d     [LANES];
   logic [PW-1:0]            s1_prod_q  [LANES];

   // Stage 2: running sums and the registered result.
   logic [AW-1:0]            acc_d      [LANES];
   logic [AW-1:0]            acc_q      [LANES];
   logic [LANES*BIT_NUM-1:0] rnd_vec;
   logic [LANES-1:0]         rnd_ovf;
   logic [LANES*BIT_NUM-1:0] out_vec_q;
   logic [LANES-1:0]         out_ovf_q;
   logic                     out_valid_q;
   logic                     out_valid_d;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign res_load  = adv && s1_valid_q && s1_last_q;
   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_ovf   = out_ovf_q;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [PW-1:0] a_ext;
      logic [PW-1:0] b_ext;

      // Sign-extend to full product width; the low PW bits of the unsigned
      // product are then the exact signed product.
      assign a_ext     = {{BIT_NUM{a_vec[g*BIT_NUM+BIT_NUM-1]}}, a_vec[g*BIT_NUM +: BIT_NUM]};
      assign b_ext     = {{BIT_NUM{b[BIT_NUM-1]}}, b};
      assign prod_d[g] = a_ext * b_ext;

      // A first beat restarts the sum, which also drops any unfinished group.
      assign acc_d[g]  = (s1_first_q ? '0 : acc_q[g])
                       + {{GUARD{s1_prod_q[g][PW-1]}}, s1_prod_q[g]};

      fxp_round_sat #(
         .BIT_NUM  (BIT_NUM),
         .FRAC_NUM (FRAC_NUM),
         .ACC_W    (AW)
      ) u_round_sat (
         .acc_i    (acc_d[g]),
         .mode_i   (s1_mode_q),
         .sat_en_i (s1_sat_q),
         .val_o    (rnd_vec[g*BIT_NUM +: BIT_NUM]),
         .ovf_o    (rnd_ovf[g])
      );
   end

   // Result valid: set when a last beat completes, cleared when drained.
   always_comb begin
      out_valid_d = out_valid_q;
      if (res_load) begin
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Pipeline registers: everything moves together on adv, holds otherwise.
   always_ff @(posedge clk) begin
      if (srst) begin
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_sat_q    <= 1'b0;
         s1_mode_q   <= 2'd0;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_ovf_q   <= '0;
         for (int i = 0; i < LANES; i++) begin
            s1_prod_q[i] <= '0;
            acc_q[i]     <= '0;
         end
      end else begin
         out_valid_q <= out_valid_d;
         if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_first_q <= in_first;
               s1_last_q  <= in_last;
               s1_sat_q   <= sat_en;
               s1_mode_q  <= round_mode;
               for (int i = 0; i < LANES; i++) begin
                  s1_prod_q[i] <= prod_d[i];
               end
            end
            if (s1_valid_q) begin
               for (int i = 0; i < LANES; i++) begin
                  acc_q[i] <= acc_d[i];
               end
            end
            if (res_load) begin
               out_vec_q <= rnd_vec;
               out_ovf_q <= rnd_ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_col_nx1.sv
// Bench for mac_col_nx1: directed scenarios followed by random groups, checked
// against an arithmetic reference model and an expected-result queue.
module tb_mac_col_nx1;

   localparam int LANES = 4;
   localparam int BW    = 18;
   localparam int FRAC  = 9;
   localparam int GUARD = 4;
   localparam int VW    = LANES * BW;
   localparam int W     = VW + LANES;

   logic            clk;
   logic            srst;
   logic            in_valid;
   logic            in_ready;
   logic            in_first;
   logic            in_last;
   logic [VW-1:0]   a_vec;
   logic [BW-1:0]   b;
   logic [1:0]      round_mode;
   logic            sat_en;
   logic            out_valid;
   logic            out_ready;
   logic [VW-1:0]   out_vec;
   logic [LANES-1:0] out_ovf;

   logic [W-1:0]    exp_q[$];
   longint          acc_m[LANES];
   int              n_tests;
   int              n_fail;
   int              n_out;
   int              n_exp;
   int              rdy_mode;

   mac_col_nx1 #(
      .LANES    (LANES),
      .BIT_NUM  (BW),
      .FRAC_NUM (FRAC),
      .GUARD    (GUARD)
   ) dut (
      .clk        (clk),
      .srst       (srst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_first   (in_first),
      .in_last    (in_last),
      .a_vec      (a_vec),
      .b          (b),
      .round_mode (round_mode),
      .sat_en     (sat_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_vec    (out_vec),
      .out_ovf    (out_ovf)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic longint floor_div(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   // Returns {ovf, value} for one lane, straight from the rounding rules.
   function automatic logic [BW:0] ref_lane(input longint acc, input logic [1:0] mode,
                                            input logic sat);
      longint one_lsb;
      longint q;
      longint mx;
      longint mn;
      longint mask;
      logic   o;
      logic [BW-1:0] v;
      one_lsb = longint'(1) << FRAC;
      mx      = (longint'(1) << (BW - 1)) - 1;
      mn      = -(longint'(1) << (BW - 1));
      mask    = (longint'(1) << BW) - 1;
      case (mode)
         2'd0:    q = floor_div(acc, one_lsb);
         2'd1:    q = floor_div(acc, one_lsb) + ((acc < 0) ? 1 : 0);
         default: q = floor_div(acc + one_lsb / 2, one_lsb);
      endcase
      o = (q > mx) || (q < mn);
      if (o && sat) v = (q > mx) ? BW'(mx) : BW'(mn & mask);
      else          v = BW'(q & mask);
      return {o, v};
   endfunction

   task automatic model_beat(input logic first, input logic last, input logic [VW-1:0] a,
                             input logic [BW-1:0] bb, input logic [1:0] rm, input logic se);
      logic [W-1:0] e;
      logic [BW:0]  r;
      longint       ai;
      longint       bi;
      e  = '0;
      bi = longint'($signed(bb));
      for (int i = 0; i < LANES; i++) begin
         ai = longint'($signed(a[i*BW +: BW]));
         if (first) acc_m[i] = 0;
         acc_m[i] = acc_m[i] + ai * bi;
         r = ref_lane(acc_m[i], rm, se);
         e[i*BW +: BW] = r[BW-1:0];
         e[VW+i]       = r[BW];
      end
      if (last) begin
         exp_q.push_back(e);
         n_exp++;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every cycle a result is shown it must equal the queue head,
   // which is popped only when the consumer takes it.
   always begin
      @(negedge clk);
      #2;
      if (!srst && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 128'(out_valid), 128'(1'b0));
         end else begin
            check("result", 128'({out_ovf, out_vec}), 128'(exp_q[0]));
            if (!out_ready) begin
               check("stall_in_ready", 128'(in_ready), 128'(1'b0));
            end else begin
               void'(exp_q.pop_front());
               n_out++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic pick_ready();
      case (rdy_mode)
         0:       return 1'b1;
         1:       return ($urandom_range(0, 3) != 0);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [BW-1:0] rnd_val();
      if ($urandom_range(0, 1) == 1) return BW'($urandom_range(0, (1 << BW) - 1));
      return BW'($urandom_range(0, 2047)) - BW'(1024);
   endfunction

   task automatic send_beat(input logic first, input logic last, input logic [VW-1:0] a,
                            input logic [BW-1:0] bb, input logic [1:0] rm, input logic se);
      int   tries;
      logic taken;
      tries = 0;
      taken = 1'b0;
      while (!taken) begin
         @(negedge clk);
         in_valid   = 1'b1;
         in_first   = first;
         in_last    = last;
         a_vec      = a;
         b          = bb;
         round_mode = rm;
         sat_en     = se;
         out_ready  = pick_ready();
         #1;
         taken = in_ready;
         @(posedge clk);
         tries++;
         if (!taken && tries >= 200) begin
            check("accept_timeout", 128'(taken), 128'(1'b1));
            break;
         end
      end
      if (taken) model_beat(first, last, a, bb, rm, se);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #3;
         if (exp_q.size() == 0) break;
      end
      check("drain_empty", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      srst     = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      srst = 1'b0;
      for (int i = 0; i < LANES; i++) acc_m[i] = 0;
      exp_q.delete();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [VW-1:0] a_t;
      int            base;
      int            len;
      logic [1:0]    rm;
      logic          se;

      n_tests = 0; n_fail = 0; n_out = 0; n_exp = 0; rdy_mode = 0;
      srst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      a_vec = '0; b = '0; round_mode = 2'd0; sat_en = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < LANES; i++) acc_m[i] = 0;

      do_reset();
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(1'b0));
      check("rst_out_vec",   128'(out_vec),   128'(0));
      check("rst_out_ovf",   128'(out_ovf),   128'(0));
      check("rst_in_ready",  128'(in_ready),  128'(1'b1));

      // No first after reset: accumulates onto zero.
      a_t = '0; a_t[BW-1:0] = 18'd512;
      send_beat(1'b0, 1'b1, a_t, 18'd512, 2'd0, 1'b0);
      drain();

      // Single-beat group, two-cycle latency, fixed expected lanes.
      send_beat(1'b1, 1'b1, {18'd0, 18'd768, 18'h3FE00, 18'd512}, 18'd1024, 2'd0, 1'b0);
      @(negedge clk); #1;
      check("lat_t1", 128'(out_valid), 128'(1'b0));
      @(negedge clk); #1;
      check("lat_t2", 128'(out_valid), 128'(1'b1));
      check("req037_vec", 128'(out_vec), 128'({18'd0, 18'd1536, 18'h3FC00, 18'd1024}));
      check("req037_ovf", 128'(out_ovf), 128'(0));
      drain();

      // Rounding modes on -1 LSB of fraction.
      a_t = '0; a_t[BW-1:0] = 18'h3FFFF;
      for (int m = 0; m < 3; m++) send_beat(1'b1, 1'b1, a_t, 18'd1, 2'(m), 1'b0);
      drain();

      // Three-beat group yields exactly one result.
      base = n_out;
      a_t = '0; a_t[BW-1:0] = 18'd512;
      send_beat(1'b1, 1'b0, a_t, 18'd512, 2'd0, 1'b0);
      send_beat(1'b0, 1'b0, a_t, 18'd512, 2'd0, 1'b0);
      send_beat(1'b0, 1'b1, a_t, 18'd512, 2'd0, 1'b0);
      drain();
      check("group3_count", 128'(n_out - base), 128'(1));

      // Restart inside an open group discards the partial sum silently.
      base = n_out;
      send_beat(1'b1, 1'b0, {4{18'd1000}}, 18'd777, 2'd2, 1'b0);
      send_beat(1'b1, 1'b0, {4{18'd3000}}, 18'd5, 2'd1, 1'b1);
      send_beat(1'b1, 1'b1, {4{18'd200}}, 18'd600, 2'd2, 1'b1);
      drain();
      check("restart_count", 128'(n_out - base), 128'(1));

      // Overflow with saturation and with wrap.
      send_beat(1'b1, 1'b1, {4{18'd131071}}, 18'd131071, 2'd0, 1'b1);
      send_beat(1'b1, 1'b1, {4{18'd131071}}, 18'd131071, 2'd0, 1'b0);
      drain();

      // Consumer stall for 5 cycles during back-to-back groups.
      base = n_out;
      rdy_mode = 2;
      send_beat(1'b1, 1'b1, {4{18'd100}}, 18'd1024, 2'd0, 1'b0);
      send_beat(1'b1, 1'b1, {4{18'd200}}, 18'd1024, 2'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
         a_vec = {4{18'd300}}; b = 18'd1024; round_mode = 2'd0; sat_en = 1'b0;
         out_ready = 1'b0;
         #1;
         check("stall_ready_low", 128'(in_ready), 128'(1'b0));
         check("stall_valid", 128'(out_valid), 128'(1'b1));
      end
      rdy_mode = 0;
      send_beat(1'b1, 1'b1, {4{18'd300}}, 18'd1024, 2'd0, 1'b0);
      drain();
      check("stall_count", 128'(n_out - base), 128'(3));

      // Reset in the middle of a group, then a fresh single-beat group.
      a_t = '0; a_t[BW-1:0] = 18'd512;
      send_beat(1'b1, 1'b0, {4{18'd9000}}, 18'd9000, 2'd0, 1'b0);
      send_beat(1'b0, 1'b0, {4{18'd9000}}, 18'd9000, 2'd0, 1'b0);
      do_reset();
      #1;
      check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
      send_beat(1'b1, 1'b1, a_t, 18'd512, 2'd0, 1'b0);
      drain();

      // Random groups with random back-pressure.
      rdy_mode = 1;
      for (int g = 0; g < 60; g++) begin
         len = $urandom_range(1, 4);
         for (int k = 0; k < len; k++) begin
            for (int i = 0; i < LANES; i++) a_t[i*BW +: BW] = rnd_val();
            rm = 2'($urandom_range(0, 3));
            se = 1'($urandom_range(0, 1));
            send_beat(k == 0, k == len - 1, a_t, rnd_val(), rm, se);
         end
      end
      rdy_mode = 0;
      drain();
      check("total_results", 128'(n_out), 128'(n_exp));
      @(negedge clk); #1;
      check("final_idle", 128'(out_valid), 128'(1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
